// File: rtl/pgnoc_pkg.sv
// pgnoc_pkg: shared definitions for the packet link transmitter.
//   - flit type codes carried in the two MSBs of every flit
//   - FSM state encoding used by link_transmitter
package pgnoc_pkg;

  // Flit type codes, placed in bits [BUS_SIZE-1:BUS_SIZE-2] of a flit.
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    BODY = 2'b10
  } tx_state_t;

endpackage : pgnoc_pkg

// File: rtl/tx_shift_reg.sv
// tx_shift_reg: holds the captured packet payload and presents it
// MSB-first, FIELD_SIZE bits at a time.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, clears the register
//   load   - capture data on this edge
//   shift  - discard the current field and advance to the next one
//   data   - payload to capture (FLITS*FIELD_SIZE bits)
//   field  - current field (top FIELD_SIZE bits of the register)
module tx_shift_reg #(
  parameter int FIELD_SIZE = 6,
  parameter int FLITS      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        shift,
  input  logic [FLITS*FIELD_SIZE-1:0] data,
  output logic [FIELD_SIZE-1:0]       field
);

  localparam int TOTAL = FLITS * FIELD_SIZE;

  logic [TOTAL-1:0] payload;

  // Load has priority over shift; the two never coincide in practice
  // because loading only happens while the transmitter is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      payload <= '0;
    end else if (load) begin
      payload <= data;
    end else if (shift) begin
      payload <= payload << FIELD_SIZE;
    end
  end

  assign field = payload[TOTAL-1 -: FIELD_SIZE];

endmodule : tx_shift_reg

// File: rtl/link_transmitter.sv
// link_transmitter: turns a parallel packet (destination + payload) into a
// head flit followed by BODY_FLITS body flits, the last one typed tail,
// using a valid/ready handshake on the link side.
//
// Optional feature: define LINK_TX_STATS_EN to build a 16-bit counter of
// completed packets on sent_cnt_o; otherwise sent_cnt_o is constant 0.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   pkt_valid_i - local node offers a packet
//   pkt_ready_o - transmitter is idle and can take a packet
//   pkt_dest_i  - destination node address
//   pkt_data_i  - payload, sent MSB-first
//   data_o      - flit on the link (0 when idle)
//   wr_ready_o  - data_o holds a valid flit
//   r_ready_i   - link receiver reads the flit this cycle
//   sent_cnt_o  - count of completed packets (stats build only)
module link_transmitter
  import pgnoc_pkg::*;
#(
  parameter int BUS_SIZE   = 8,
  parameter int ADDR_SIZE  = 4,
  parameter int BODY_FLITS = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pkt_valid_i,
  output logic                                pkt_ready_o,
  input  logic [ADDR_SIZE-1:0]                pkt_dest_i,
  input  logic [BODY_FLITS*(BUS_SIZE-2)-1:0]  pkt_data_i,
  output logic [BUS_SIZE-1:0]                 data_o,
  output logic                                wr_ready_o,
  input  logic                                r_ready_i,
  output logic [15:0]                         sent_cnt_o
);

  localparam int FIELD_SIZE = BUS_SIZE - 2;
  localparam int CNT_W      = (BODY_FLITS > 1) ? $clog2(BODY_FLITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BODY_FLITS - 1);

  tx_state_t             state, state_next;
  logic [ADDR_SIZE-1:0]  dest_q;
  logic [CNT_W-1:0]      flit_cnt;
  logic [FIELD_SIZE-1:0] body_field;
  logic [FIELD_SIZE-1:0] head_field;
  logic                  load;
  logic                  shift;
  logic                  last_body;

  tx_shift_reg #(
    .FIELD_SIZE(FIELD_SIZE),
    .FLITS     (BODY_FLITS)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .data (pkt_data_i),
    .field(body_field)
  );

  assign last_body = (flit_cnt == LAST_IDX);

  // Head field: destination in the low bits, remaining field bits zero.
  always_comb begin
    head_field                = '0;
    head_field[ADDR_SIZE-1:0] = dest_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs depend only on registered state, so they hold still for any
  // stall length until the receiver takes the flit.
  always_comb begin
    state_next  = state;
    pkt_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    data_o      = '0;
    load        = 1'b0;
    shift       = 1'b0;
    case (state)
      IDLE: begin
        pkt_ready_o = 1'b1;
        if (pkt_valid_i) begin
          load       = 1'b1;
          state_next = HEAD;
        end
      end
      HEAD: begin
        wr_ready_o = 1'b1;
        data_o     = {FLIT_HEAD, head_field};
        if (r_ready_i) begin
          state_next = BODY;
        end
      end
      BODY: begin
        wr_ready_o = 1'b1;
        data_o     = {(last_body ? FLIT_TAIL : FLIT_BODY), body_field};
        if (r_ready_i) begin
          shift = 1'b1;
          if (last_body) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Destination is captured only at acceptance, so later pkt_* activity
  // cannot disturb a packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q <= '0;
    end else if (load) begin
      dest_q <= pkt_dest_i;
    end
  end

  // Index of the body flit currently on the link; wraps to 0 after the tail.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      flit_cnt <= '0;
    end else if (shift) begin
      flit_cnt <= last_body ? '0 : flit_cnt + CNT_W'(1);
    end
  end

`ifdef LINK_TX_STATS_EN
  logic [15:0] sent_cnt;

  // Counts tail transfers; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_cnt <= '0;
    end else if (shift && last_body) begin
      sent_cnt <= sent_cnt + 16'd1;
    end
  end

  assign sent_cnt_o = sent_cnt;
`else
  assign sent_cnt_o = '0;
`endif

endmodule : link_transmitter

// File: tb/tb_link_transmitter.sv
// tb_link_transmitter: scoreboard bench for link_transmitter at default
// parameters. Expected flits are queued when a packet is accepted and
// compared by a monitor whenever a flit transfers on the link.
module tb_link_transmitter;

   localparam int BUS_SIZE   = 8;
   localparam int ADDR_SIZE  = 4;
   localparam int BODY_FLITS = 2;
   localparam int FIELD_W    = BUS_SIZE - 2;
   localparam int DATA_W     = BODY_FLITS * FIELD_W;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 pkt_valid = 1'b0;
   logic                 pkt_ready;
   logic [ADDR_SIZE-1:0] pkt_dest = '0;
   logic [DATA_W-1:0]    pkt_data = '0;
   logic [BUS_SIZE-1:0]  data_out;
   logic                 wr_ready;
   logic                 r_ready = 1'b0;
   logic [15:0]          sent_cnt;

   int assertCount = 0;
   int failCount   = 0;

   logic [BUS_SIZE-1:0] expQueue[$];
   int                  tailCount = 0;
   int                  lastGap   = -1;
   int                  gapCount  = 0;
   bit                  afterTail = 1'b0;
   bit                  stalled   = 1'b0;
   logic [BUS_SIZE-1:0] stallData = '0;

   link_transmitter #(
      .BUS_SIZE  (BUS_SIZE),
      .ADDR_SIZE (ADDR_SIZE),
      .BODY_FLITS(BODY_FLITS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pkt_valid_i(pkt_valid),
      .pkt_ready_o(pkt_ready),
      .pkt_dest_i (pkt_dest),
      .pkt_data_i (pkt_data),
      .data_o     (data_out),
      .wr_ready_o (wr_ready),
      .r_ready_i  (r_ready),
      .sent_cnt_o (sent_cnt)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Builds the expected flit stream for a packet from first principles.
   task automatic pushExpected(input logic [ADDR_SIZE-1:0] dest,
                               input logic [DATA_W-1:0] data);
      logic [FIELD_W-1:0] fld;
      fld = '0;
      fld[ADDR_SIZE-1:0] = dest;
      expQueue.push_back({2'b01, fld});
      for (int i = 0; i < BODY_FLITS; i++) begin
         fld = data[(BODY_FLITS-1-i)*FIELD_W +: FIELD_W];
         expQueue.push_back({(i == BODY_FLITS-1) ? 2'b10 : 2'b00, fld});
      end
   endtask

   // Offers a packet and waits (bounded) for acceptance, then checks that
   // the head shows up in the very next cycle.
   task automatic applyStimulus(input logic [ADDR_SIZE-1:0] dest,
                                input logic [DATA_W-1:0] data,
                                input bit keepValid);
      bit acc;
      bit done;
      logic [FIELD_W-1:0] fld;
      done      = 1'b0;
      pkt_dest  = dest;
      pkt_data  = data;
      pkt_valid = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         acc = pkt_ready;
         if (acc) pushExpected(dest, data);
         @(posedge clk);
         #1;
         done = acc;
      end
      if (!done) checkOutput("accept timeout", 32'd0, 32'd1);
      if (!keepValid) pkt_valid = 1'b0;
      fld = '0;
      fld[ADDR_SIZE-1:0] = dest;
      checkOutput("head latency wr_ready", {31'd0, wr_ready}, 32'd1);
      checkOutput("head latency data", {24'd0, data_out}, {24'd0, 2'b01, fld});
   endtask

   // Bounded wait until the packet drains and the transmitter is idle.
   task automatic waitIdle();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(posedge clk);
         #1;
         done = pkt_ready && (expQueue.size() == 0);
      end
      checkOutput("drain to idle", {31'd0, done}, 32'd1);
   endtask

   // Link monitor: checks transferred flits against the scoreboard, stall
   // stability and the idle gap after each tail.
   always @(negedge clk) begin
      if (rst) begin
         expQueue.delete();
         tailCount = 0;
         stalled   = 1'b0;
         afterTail = 1'b0;
      end else begin
         if (stalled) begin
            checkOutput("stall hold wr_ready", {31'd0, wr_ready}, 32'd1);
            checkOutput("stall hold data", {24'd0, data_out}, {24'd0, stallData});
         end
         if (afterTail) begin
            if (!wr_ready) gapCount++;
            else begin
               lastGap   = gapCount;
               afterTail = 1'b0;
            end
         end
         if (!wr_ready) begin
            checkOutput("idle data zero", {24'd0, data_out}, 32'd0);
         end
         stalled = wr_ready && !r_ready;
         stallData = data_out;
         if (wr_ready && r_ready) begin
            if (expQueue.size() == 0) begin
               checkOutput("unexpected flit", {24'd0, data_out}, 32'hFFFF_FFFF);
            end else begin
               logic [BUS_SIZE-1:0] e;
               e = expQueue.pop_front();
               checkOutput("flit data", {24'd0, data_out}, {24'd0, e});
               if (e[BUS_SIZE-1 -: 2] == 2'b10) begin
                  tailCount++;
                  afterTail = 1'b1;
                  gapCount  = 0;
               end
            end
         end
      end
   end

   function automatic logic [15:0] expectedSent();
`ifdef LINK_TX_STATS_EN
      return 16'(tailCount);
`else
      return 16'd0;
`endif
   endfunction

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset pkt_ready", {31'd0, pkt_ready}, 32'd1);
      checkOutput("reset wr_ready", {31'd0, wr_ready}, 32'd0);
      checkOutput("reset data", {24'd0, data_out}, 32'd0);
      checkOutput("reset sent_cnt", {16'd0, sent_cnt}, 32'd0);

      // Fully ready link: 45, 2A, BC on consecutive cycles
      r_ready = 1'b1;
      applyStimulus(4'h5, 12'hABC, 1'b0);
      @(posedge clk); #1;
      checkOutput("body0 consecutive", {24'd0, data_out}, 32'h2A);
      @(posedge clk); #1;
      checkOutput("tail consecutive", {24'd0, data_out}, 32'hBC);
      @(posedge clk); #1;
      checkOutput("pkt_ready after tail", {31'd0, pkt_ready}, 32'd1);

      // Five-cycle stall on the first body flit
      applyStimulus(4'h5, 12'hABC, 1'b0);
      @(posedge clk); #1;
      r_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("stall body data", {24'd0, data_out}, 32'h2A);
      checkOutput("stall body wr_ready", {31'd0, wr_ready}, 32'd1);
      r_ready = 1'b1;
      waitIdle();

      // Inputs change mid-packet; flits must follow the captured values
      applyStimulus(4'hA, 12'h5F3, 1'b0);
      pkt_valid = 1'b1;
      pkt_dest  = 4'h3;
      pkt_data  = 12'h123;
      @(posedge clk); #1;
      pkt_data  = 12'hFFF;
      pkt_valid = 1'b0;
      waitIdle();
      checkOutput("sent_cnt after 3", {16'd0, sent_cnt}, {16'd0, expectedSent()});
`ifndef LINK_TX_STATS_EN
      checkOutput("sent_cnt tied off", {16'd0, sent_cnt}, 32'd0);
`endif

      // Back-to-back packets with valid held high: one idle bubble
      lastGap = -1;
      applyStimulus(4'h1, 12'h0C3, 1'b1);
      applyStimulus(4'hE, 12'hF0F, 1'b0);
      waitIdle();
      checkOutput("back-to-back gap", 32'(lastGap), 32'd1);

      // Reset in the middle of the body abandons the packet
      applyStimulus(4'h7, 12'h9D2, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("mid reset wr_ready", {31'd0, wr_ready}, 32'd0);
      checkOutput("mid reset data", {24'd0, data_out}, 32'd0);
      checkOutput("mid reset pkt_ready", {31'd0, pkt_ready}, 32'd1);
      checkOutput("mid reset sent_cnt", {16'd0, sent_cnt}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("no tail after reset", {31'd0, wr_ready}, 32'd0);

      // Recovery after reset
      applyStimulus(4'h2, 12'h456, 1'b0);
      waitIdle();
      checkOutput("sent_cnt after recovery", {16'd0, sent_cnt}, {16'd0, expectedSent()});

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Global time bound so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule : tb_link_transmitter
